// File: rtl/rng_req_arbiter_if.sv
// rng_req_arbiter_if: control, datapath and requester signals of the RNG sequencer/arbiter
interface rng_req_arbiter_if #(parameter int NUM_REQ = 4);
  logic               start_i;
  logic               reseed_i;
  logic [127:0]       seed_i;
  logic               rng_load_o;
  logic [127:0]       rng_seed_o;
  logic [63:0]        rng_num_i;
  logic               rng_num_valid_i;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [63:0]        rand_o;
  logic [4:0]         fifo_cnt_o;
  logic [1:0]         state_o;
  logic               health_err_o;
  modport slave (
    input  start_i, reseed_i, seed_i, rng_num_i, rng_num_valid_i, req_i,
    output rng_load_o, rng_seed_o, gnt_o, rand_o, fifo_cnt_o, state_o, health_err_o
  );
  modport master (
    output start_i, reseed_i, seed_i, rng_num_i, rng_num_valid_i, req_i,
    input  rng_load_o, rng_seed_o, gnt_o, rand_o, fifo_cnt_o, state_o, health_err_o
  );
endinterface

// File: rtl/rng_req_arbiter.sv
// rng_req_arbiter: RNG seed/warm-up sequencer, word FIFO and round-robin distributor.
// Optional RNG_REPETITION_TEST_EN adds a consecutive-repeat health test.
module rng_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int WARMUP_WORDS    = 8,
  parameter int RESEED_INTERVAL = 1024
) (
  input logic clk,
  input logic rst,
  rng_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;
  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(RESEED_INTERVAL + 2);
  state_t             state_q, state_d;
  logic [127:0]       seed_q, seed_d;
  logic               pend_q, pend_d;
  logic [7:0]         warm_q, warm_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [63:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_q, wr_q;
  logic [4:0]         cnt_q;
  logic [PW-1:0]      ptr_q, win;
  logic [NUM_REQ-1:0] gnt_q, ereq;
  logic [63:0]        rand_q;
  logic               found, trig, rep, push, pop, flush, full;
  // last cycle's winner is masked so a req held one cycle too long is not served twice
  assign ereq  = bus.req_i & ~gnt_q;
  assign full  = cnt_q == 5'(FIFO_DEPTH);
  assign trig  = state_q == RUN && (bus.reseed_i || rep ||
                 (RESEED_INTERVAL != 0 && dcnt_q == DW'(RESEED_INTERVAL)));
  assign pop   = state_q == RUN && !trig && found && cnt_q != 5'd0;
  assign push  = state_q == RUN && bus.rng_num_valid_i && !rep && (!full || pop);
  assign flush = state_d == LOAD;
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && ereq[PW'(j)]) begin
        found = 1'b1;
        win = PW'(j);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    pend_d  = pend_q;
    warm_d  = warm_q;
    dcnt_d  = pop ? dcnt_q + 1'b1 : dcnt_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        seed_d  = bus.seed_i;
        state_d = LOAD;
      end
      LOAD: begin
        state_d = WARMUP;
        warm_d  = '0;
        dcnt_d  = '0;
        pend_d  = bus.reseed_i;
        seed_d  = bus.reseed_i ? bus.seed_i : seed_q;
      end
      WARMUP: begin
        pend_d = pend_q | bus.reseed_i;
        seed_d = bus.reseed_i ? bus.seed_i : seed_q;
        if (bus.rng_num_valid_i) begin
          warm_d = warm_q + 1'b1;
          if (warm_q == 8'(WARMUP_WORDS - 1)) state_d = (pend_q || bus.reseed_i) ? LOAD : RUN;
        end
      end
      RUN: if (trig) begin
        state_d = LOAD;
        seed_d  = bus.reseed_i ? bus.seed_i : seed_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
      pend_q  <= 1'b0;
      warm_q  <= '0;
      dcnt_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      pend_q  <= pend_d;
      warm_q  <= warm_d;
      dcnt_q  <= dcnt_d;
      gnt_q   <= pop ? NUM_REQ'(1) << win : '0;
      rand_q  <= pop ? mem[rd_q] : '0;
      if (flush) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_q + AW'(pop);
        wr_q  <= wr_q + AW'(push);
        cnt_q <= cnt_q + 5'(push) - 5'(pop);
      end
      if (pop) ptr_q <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
  // when full with a pop, the head is read before this write lands on the same slot
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.rng_num_i;
  end
`ifdef RNG_REPETITION_TEST_EN
  logic [63:0] prev_q;
  logic        prev_v_q, herr_q;
  assign rep = state_q == RUN && bus.rng_num_valid_i && prev_v_q && bus.rng_num_i == prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      prev_v_q <= 1'b0;
      herr_q   <= 1'b0;
    end else begin
      if (flush) prev_v_q <= 1'b0;
      else if (state_q == RUN && bus.rng_num_valid_i) begin
        prev_q   <= bus.rng_num_i;
        prev_v_q <= 1'b1;
      end
      if (rep) herr_q <= 1'b1;
    end
  end
  assign bus.health_err_o = herr_q;
`else
  assign rep = 1'b0;
  assign bus.health_err_o = 1'b0;
`endif
  assign bus.rng_load_o = state_q == LOAD;
  assign bus.rng_seed_o = seed_q;
  assign bus.gnt_o      = gnt_q;
  assign bus.rand_o     = rand_q;
  assign bus.fifo_cnt_o = cnt_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_rng_req_arbiter.sv
// tb_rng_req_arbiter: vector table plus directed sequences for rng_req_arbiter
module tb_rng_req_arbiter;
  localparam logic [127:0] SA = {16{8'hA5}};
  localparam logic [127:0] SB = {16{8'hB6}};
  localparam logic [127:0] SC = {16{8'hC7}};
  typedef struct {
    logic        st, rs, v;
    logic [63:0] n;
    logic [3:0]  rq;
    logic [1:0]  es;
    logic        el;
    logic [4:0]  ec;
    logic [3:0]  eg;
    logic [63:0] er;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];
  rng_req_arbiter_if #(.NUM_REQ(4)) b0();
  rng_req_arbiter_if #(.NUM_REQ(4)) b1();
  rng_req_arbiter #(.NUM_REQ(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rng_req_arbiter #(.NUM_REQ(4), .RESEED_INTERVAL(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  function automatic logic [63:0] w(int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction
  function automatic logic [63:0] wm(int i);
    return 64'hDEAD_0000_0000_0000 + 64'(i);
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic st, rs, v, input logic [63:0] n, input logic [3:0] rq,
                     input logic [1:0] es, input logic el, input logic [4:0] ec,
                     input logic [3:0] eg, input logic [63:0] er);
    vec_t t;
    t.st = st; t.rs = rs; t.v = v; t.n = n; t.rq = rq;
    t.es = es; t.el = el; t.ec = ec; t.eg = eg; t.er = er;
    tbl.push_back(t);
  endtask
  task automatic idle0;
    b0.start_i = 0; b0.reseed_i = 0; b0.seed_i = '0;
    b0.rng_num_i = '0; b0.rng_num_valid_i = 0; b0.req_i = '0;
  endtask
  task automatic idle1;
    b1.start_i = 0; b1.reseed_i = 0; b1.seed_i = '0;
    b1.rng_num_i = '0; b1.rng_num_valid_i = 0; b1.req_i = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [127:0] mseed;
    int ng, k;
    logic saw;
    idle0();
    idle1();
    add(1,0,0,0,4'h0, 1,1,0,0,0);
    add(0,0,0,0,4'hF, 2,0,0,0,0);
    for (int i = 0; i < 7; i++) add(0,0,1,wm(i),4'hF, 2,0,0,0,0);
    add(0,0,1,wm(7),4'hF, 3,0,0,0,0);
    for (int i = 1; i <= 6; i++) add(0,0,1,w(i),4'h0, 3,0,(i < 4) ? 5'(i) : 5'd4,0,0);
    add(0,0,0,0,4'hF, 3,0,3,4'h1,w(1));
    add(0,0,0,0,4'hF, 3,0,2,4'h2,w(2));
    add(0,0,0,0,4'hF, 3,0,1,4'h4,w(3));
    add(0,0,0,0,4'hF, 3,0,0,4'h8,w(4));
    add(0,0,0,0,4'hF, 3,0,0,4'h0,0);
    add(0,0,1,w(7),4'hF, 3,0,1,4'h0,0);
    add(0,0,0,0,4'hF, 3,0,0,4'h1,w(7));
    for (int i = 8; i <= 11; i++) add(0,0,1,w(i),4'h0, 3,0,5'(i - 7),0,0);
    add(0,0,1,w(12),4'h1, 3,0,4,4'h1,w(8));
    add(0,0,0,0,4'h2, 3,0,3,4'h2,w(9));
    add(0,0,0,0,4'h4, 3,0,2,4'h4,w(10));
    add(0,0,0,0,4'h8, 3,0,1,4'h8,w(11));
    add(0,0,0,0,4'h1, 3,0,0,4'h1,w(12));
    add(0,0,1,w(13),4'h0, 3,0,1,0,0);
    add(0,0,1,w(14),4'h0, 3,0,2,0,0);
    add(0,0,0,0,4'h1, 3,0,1,4'h1,w(13));
    add(0,0,0,0,4'h1, 3,0,1,4'h0,0);
    add(0,0,0,0,4'h1, 3,0,0,4'h1,w(14));
    add(0,0,1,w(15),4'h0, 3,0,1,0,0);
    add(0,1,0,0,4'h0, 1,1,0,0,0);
    add(0,0,0,0,4'h0, 2,0,0,0,0);
    repeat (2) step();
    chk("reset0", {b0.state_o, b0.rng_load_o, b0.fifo_cnt_o, b0.gnt_o, b0.rand_o, b0.rng_seed_o, b0.health_err_o}, '0);
    chk("reset1", {b1.state_o, b1.rng_load_o, b1.fifo_cnt_o, b1.gnt_o, b1.rand_o, b1.rng_seed_o, b1.health_err_o}, '0);
    rst = 0;
    step();
    mseed = '0;
    foreach (tbl[i]) begin
      b0.start_i = tbl[i].st; b0.reseed_i = tbl[i].rs;
      b0.seed_i = tbl[i].st ? SA : SB;
      b0.rng_num_valid_i = tbl[i].v; b0.rng_num_i = tbl[i].n; b0.req_i = tbl[i].rq;
      if (tbl[i].st || tbl[i].rs) mseed = tbl[i].st ? SA : SB;
      step();
      chk($sformatf("vec%0d", i),
          {b0.state_o, b0.rng_load_o, b0.fifo_cnt_o, b0.gnt_o, b0.rand_o, b0.health_err_o, b0.rng_seed_o},
          {tbl[i].es, tbl[i].el, tbl[i].ec, tbl[i].eg, tbl[i].er, 1'b0, mseed});
    end
    idle0();
    b1.start_i = 1; b1.seed_i = SA;
    step();
    b1.start_i = 0;
    chk("ri_load", {b1.state_o, b1.rng_load_o, b1.rng_seed_o}, {2'd1, 1'b1, SA});
    step();
    chk("ri_warm", 256'(b1.state_o), 256'(2));
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      b1.rng_num_valid_i = 1; b1.rng_num_i = wm(i); b1.req_i = 4'hF;
      step();
      if (b1.gnt_o != 0) saw = 1;
    end
    chk("ri_warm_nogrant", {b1.state_o, 1'b0, saw}, {2'd3, 1'b0, 1'b0});
    ng = 0;
    k = 1;
    for (int c = 0; c < 40 && b1.state_o != 2'd1; c++) begin
      b1.rng_num_i = w(k); k++;
      step();
      if (b1.gnt_o != 0) begin
        ng++;
        chk($sformatf("ri_rand%0d", ng), 256'(b1.rand_o), 256'(w(ng)));
      end
    end
    chk("ri_reseed", {b1.state_o, b1.rng_load_o, b1.fifo_cnt_o, 8'(ng)}, {2'd1, 1'b1, 5'd0, 8'd4});
    b1.rng_num_valid_i = 0; b1.req_i = 0;
    step();
    b1.reseed_i = 1; b1.seed_i = SC; b1.rng_num_valid_i = 1; b1.rng_num_i = wm(20);
    step();
    b1.reseed_i = 0;
    for (int i = 21; i < 28; i++) begin
      b1.rng_num_i = wm(i);
      step();
    end
    chk("ri_warm_reseed", {b1.state_o, b1.rng_load_o, b1.rng_seed_o}, {2'd1, 1'b1, SC});
    b1.rng_num_valid_i = 0;
    step();
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      b1.rng_num_valid_i = 1; b1.rng_num_i = wm(40 + i); b1.req_i = 4'hF;
      step();
      if (b1.gnt_o != 0) saw = 1;
    end
    chk("ri_warm2", {b1.state_o, saw}, {2'd3, 1'b0});
    saw = 0;
    for (int c = 0; c < 6 && !saw; c++) begin
      b1.rng_num_i = w(100 + c);
      step();
      if (b1.gnt_o != 0) begin
        saw = 1;
        chk("ri_resume", 256'(b1.rand_o), 256'(w(100)));
      end
    end
    chk("ri_resume_seen", 256'(saw), 256'(1));
    idle1();
    rst = 1;
    #2;
    chk("async_rst", {b0.state_o, b0.rng_load_o, b0.fifo_cnt_o, b0.gnt_o, b0.rand_o, b0.rng_seed_o}, '0);
    step();
    rst = 0;
    b0.reseed_i = 1; b0.seed_i = SC;
    step();
    b0.reseed_i = 0;
    chk("idle_reseed", {b0.state_o, b0.rng_seed_o}, '0);
    b0.start_i = 1; b0.seed_i = SA;
    step();
    b0.start_i = 0;
    chk("restart", {b0.state_o, b0.rng_load_o, b0.rng_seed_o}, {2'd1, 1'b1, SA});
    step();
    for (int i = 0; i < 8; i++) begin
      b0.rng_num_valid_i = 1; b0.rng_num_i = wm(60 + i);
      step();
    end
    chk("rerun", 256'(b0.state_o), 256'(3));
    b0.rng_num_i = 64'h1234;
    step();
    chk("rep_first", {b0.fifo_cnt_o, b0.health_err_o}, {5'd1, 1'b0});
    step();
`ifdef RNG_REPETITION_TEST_EN
    chk("rep_second", {b0.health_err_o, b0.rng_load_o, b0.state_o}, {1'b1, 1'b1, 2'd1});
`else
    chk("rep_second", {b0.health_err_o, b0.rng_load_o, b0.fifo_cnt_o}, {1'b0, 1'b0, 5'd2});
`endif
    b0.rng_num_valid_i = 0;
    step();
`ifdef RNG_REPETITION_TEST_EN
    chk("rep_sticky", {b0.health_err_o, b0.state_o}, {1'b1, 2'd2});
`else
    chk("rep_sticky", {b0.health_err_o, b0.state_o}, {1'b0, 2'd3});
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
